// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong game controller: state encodings,
// text-enable bit positions and the state-to-mask decode.
package pong_game_ctrl_pkg;

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } game_state_t;

  // Bit positions inside text_mask, shared with the text renderer
  localparam int TXT_SCORE = 3;
  localparam int TXT_LOGO  = 2;
  localparam int TXT_RULE  = 1;
  localparam int TXT_OVER  = 0;

  // Which text overlays are visible in each game state
  function automatic logic [3:0] mask_for(game_state_t s);
    logic [3:0] m;
    m = '0;
    m[TXT_SCORE] = 1'b1;
    case (s)
      NEWGAME: begin
        m[TXT_LOGO] = 1'b1;
        m[TXT_RULE] = 1'b1;
      end
      OVER:    m[TXT_OVER] = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd2_counter.sv
// Two-digit BCD score counter. Clear beats increment; 99 wraps to 00.
module bcd2_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] dig0,
  output logic [3:0] dig1
);

  // Ones digit rolls 9->0 and carries into tens, tens rolls 9->0
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      dig0 <= 4'd0;
      dig1 <= 4'd0;
    end else if (inc) begin
      if (dig0 == 4'd9) begin
        dig0 <= 4'd0;
        dig1 <= (dig1 == 4'd9) ? 4'd0 : dig1 + 4'd1;
      end else begin
        dig0 <= dig0 + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow sequencer for pong: new game / play / new ball / game over,
// with score, remaining balls and a frame-counted pause timer.
module pong_game_ctrl
  import pong_game_ctrl_pkg::*;
#(
  parameter logic [1:0] BALLS_INIT = 2'd3,
  parameter logic [6:0] TIMER_INIT = 7'd120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refr_tick,
  input  logic [1:0] btn,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [1:0] ball,
  output logic [6:0] timer,
  output logic [3:0] text_mask,
  output logic       gra_still,
  output logic [1:0] state
);

  game_state_t state_q, state_d;
  logic [1:0]  ball_q, ball_d;
  logic [6:0]  timer_q, timer_d;
  logic        score_clr, score_inc, timer_load;

  bcd2_counter u_score (
    .clk   (clk),
    .reset (reset),
    .clr   (score_clr),
    .inc   (score_inc),
    .dig0  (dig0),
    .dig1  (dig1)
  );

  // State, ball count and timer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NEWGAME;
      ball_q  <= BALLS_INIT;
      timer_q <= 7'd0;
    end else begin
      state_q <= state_d;
      ball_q  <= ball_d;
      timer_q <= timer_d;
    end
  end

  // Game-flow transitions and the score/ball side effects that go with them
  always_comb begin
    state_d    = state_q;
    ball_d     = ball_q;
    score_clr  = 1'b0;
    score_inc  = 1'b0;
    timer_load = 1'b0;
    case (state_q)
      NEWGAME: begin
        score_clr = 1'b1;
        ball_d    = BALLS_INIT;
        if (btn != 2'b00) begin
          state_d = PLAY;
          ball_d  = BALLS_INIT - 2'd1;
        end
      end
      PLAY: begin
        score_inc = hit;
        if (miss) begin
          timer_load = 1'b1;
          state_d    = (ball_q == 2'd0) ? OVER : NEWBALL;
        end
      end
      NEWBALL: begin
        if (timer_q == 7'd0 && btn != 2'b00) begin
          state_d = PLAY;
          ball_d  = ball_q - 2'd1;
        end
      end
      OVER: begin
        if (timer_q == 7'd0) begin
          state_d   = NEWGAME;
          score_clr = 1'b1;
          ball_d    = BALLS_INIT;
        end
      end
      default: state_d = NEWGAME;
    endcase
  end

  // Pause timer: a miss reloads it, otherwise it counts frames down to zero
  always_comb begin
    timer_d = timer_q;
    if (timer_load) begin
      timer_d = TIMER_INIT;
    end else if (refr_tick && timer_q != 7'd0) begin
      timer_d = timer_q - 7'd1;
    end
  end

  // Moore outputs decoded straight from the state register
  always_comb begin
    text_mask = mask_for(state_q);
    gra_still = (state_q != PLAY);
    state     = state_q;
    ball      = ball_q;
    timer     = timer_q;
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Self-checking bench for pong_game_ctrl: directed game scenarios followed
// by random play, all compared against a behavioural game model.
module tb_pong_game_ctrl;

  logic       clk;
  logic       reset;
  logic       refr_tick;
  logic [1:0] btn;
  logic       hit;
  logic       miss;
  logic [3:0] dig0, dig1;
  logic [1:0] ball;
  logic [6:0] timer;
  logic [3:0] text_mask;
  logic       gra_still;
  logic [1:0] state;

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model: 0=new game, 1=play, 2=new ball, 3=game over
  int mState = 0;
  int mScore = 0;
  int mBalls = 3;
  int mTimer = 0;
  int maskTable [4] = '{14, 8, 8, 9};

  pong_game_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .btn       (btn),
    .hit       (hit),
    .miss      (miss),
    .dig0      (dig0),
    .dig1      (dig1),
    .ball      (ball),
    .timer     (timer),
    .text_mask (text_mask),
    .gra_still (gra_still),
    .state     (state)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it disagrees
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  // Advance the game model by one clock edge from the rules of play
  task automatic stepModel(input bit r, input int b, input bit h, input bit m, input bit t);
    int nextTimer;
    if (r) begin
      mState = 0; mScore = 0; mBalls = 3; mTimer = 0;
      return;
    end
    nextTimer = (t && mTimer > 0) ? mTimer - 1 : mTimer;
    case (mState)
      0: begin
        mScore = 0; mBalls = 3;
        if (b != 0) begin mState = 1; mBalls = 2; end
      end
      1: begin
        if (h) mScore = (mScore + 1) % 100;
        if (m) begin
          nextTimer = 120;
          mState = (mBalls == 0) ? 3 : 2;
        end
      end
      2: if (mTimer == 0 && b != 0) begin mState = 1; mBalls = mBalls - 1; end
      default: if (mTimer == 0) begin mState = 0; mScore = 0; mBalls = 3; end
    endcase
    mTimer = nextTimer;
  endtask

  // Drive one cycle of inputs, clock it, then compare all outputs
  task automatic applyStimulus(input bit r, input logic [1:0] b, input bit h, input bit m, input bit t);
    reset = r; btn = b; hit = h; miss = m; refr_tick = t;
    @(posedge clk);
    stepModel(r, int'(b), h, m, t);
    #1;
    checkOutput("state", int'(state), mState);
    checkOutput("dig0", int'(dig0), mScore % 10);
    checkOutput("dig1", int'(dig1), mScore / 10);
    checkOutput("ball", int'(ball), mBalls);
    checkOutput("timer", int'(timer), mTimer);
    checkOutput("text_mask", int'(text_mask), maskTable[mState]);
    checkOutput("gra_still", int'(gra_still), (mState == 1) ? 0 : 1);
    reset = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; btn = 2'b00; hit = 1'b0; miss = 1'b0; refr_tick = 1'b0;

    applyStimulus(1, 2'b00, 0, 0, 0);
    checkOutput("reset_ball", int'(ball), 3);

    // Start: one button press enters play with one ball consumed
    applyStimulus(0, 2'b01, 0, 0, 0);
    checkOutput("start_state", int'(state), 1);
    checkOutput("start_ball", int'(ball), 2);

    for (int i = 0; i < 12; i++) applyStimulus(0, 2'b00, 1, 0, 0);
    checkOutput("score12_tens", int'(dig1), 1);
    checkOutput("score12_ones", int'(dig0), 2);
    for (int i = 0; i < 87; i++) applyStimulus(0, 2'b00, 1, 0, 0);
    checkOutput("score99_ones", int'(dig0), 9);
    applyStimulus(0, 2'b00, 1, 0, 0);
    checkOutput("wrap_tens", int'(dig1), 0);
    checkOutput("wrap_ones", int'(dig0), 0);

    // Miss with balls left, buttons held during the pause are ignored
    applyStimulus(0, 2'b00, 0, 1, 0);
    checkOutput("miss_timer", int'(timer), 120);
    for (int i = 0; i < 120; i++) applyStimulus(0, 2'b11, 0, 0, 1);
    checkOutput("pause_hold", int'(state), 2);
    applyStimulus(0, 2'b10, 0, 0, 0);
    checkOutput("resume_ball", int'(ball), 1);

    // Use up the last ball and run out the game-over pause
    applyStimulus(0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 120; i++) applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b01, 0, 0, 0);
    applyStimulus(0, 2'b00, 0, 1, 0);
    checkOutput("over_mask", int'(text_mask), 9);
    for (int i = 0; i < 120; i++) applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b00, 0, 0, 0);
    checkOutput("newgame_state", int'(state), 0);

    // Same-cycle hit+miss+tick at score 05 with one ball left
    applyStimulus(0, 2'b01, 0, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(0, 2'b00, 1, 0, 0);
    applyStimulus(0, 2'b00, 0, 1, 0);
    for (int i = 0; i < 120; i++) applyStimulus(0, 2'b00, 0, 0, 1);
    applyStimulus(0, 2'b01, 0, 0, 0);
    applyStimulus(0, 2'b00, 1, 1, 1);
    checkOutput("hitmiss_ones", int'(dig0), 6);
    checkOutput("hitmiss_timer", int'(timer), 120);

    // Reset in the middle of a pause
    for (int i = 0; i < 70; i++) applyStimulus(0, 2'b00, 0, 0, 1);
    checkOutput("timer50", int'(timer), 50);
    applyStimulus(1, 2'b00, 0, 0, 0);

    // Random play
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 499) == 0,
                    ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                    $urandom_range(0, 3) == 0,
                    $urandom_range(0, 29) == 0,
                    $urandom_range(0, 2) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
